// File: rtl/spi_ram_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the SPI-slave memory back-end.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_REQ  = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_TX      = 2'b11
    } state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/response handshake bundle between the SPI slave (master side) and the memory back-end.
interface spi_ram_ctrl_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W+1:0] din;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              err;

    modport master (
        output rx_valid, din, tx_ready,
        input  rx_ready, dout, tx_valid, err
    );

    modport slave (
        input  rx_valid, din, tx_ready,
        output rx_ready, dout, tx_valid, err
    );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM; one-cycle read latency, storage is never reset.
module spi_ram_mem #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes {opcode,payload} commands into RAM pointer/write/read operations and returns
// read data over a valid/ready handshake, flagging accesses beyond MEM_DEPTH.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    spi_ram_ctrl_if.slave  bus
);

    localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(MEM_DEPTH);

    // Wrap at MEM_DEPTH-1 rather than 2**ADDR_W so bursts stay inside the populated RAM.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              tx_valid_q, tx_valid_d;
    logic              err_q, err_d;

    logic              accept;
    logic              wr_in_range;
    logic              rd_in_range;
    opcode_e           opcode;
    logic [DATA_W-1:0] payload;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign opcode      = opcode_e'(bus.din[DATA_W+1:DATA_W]);
    assign payload     = bus.din[DATA_W-1:0];
    assign accept      = bus.rx_valid & (state_q == ST_IDLE);
    assign wr_in_range = ({1'b0, wr_ptr_q} < DepthL);
    assign rd_in_range = ({1'b0, rd_ptr_q} < DepthL);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = rd_ptr_q;
        mem_wdata  = payload;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (opcode)
                        OP_WR_ADDR: wr_ptr_d = payload[ADDR_W-1:0];
                        OP_WR_DATA: begin
                            if (wr_in_range) begin
                                mem_en   = 1'b1;
                                mem_we   = 1'b1;
                                mem_addr = wr_ptr_q;
                            end else begin
                                err_d = 1'b1;
                            end
                            if (AUTO_INC) begin
                                wr_ptr_d = ptr_inc(wr_ptr_q);
                            end
                        end
                        OP_RD_ADDR: rd_ptr_d = payload[ADDR_W-1:0];
                        OP_RD_DATA: state_d  = ST_RD_REQ;
                        default:    state_d  = ST_IDLE;
                    endcase
                end
            end
            ST_RD_REQ: begin
                mem_en  = rd_in_range;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Out-of-range reads still answer (with zero) so the master never stalls.
                dout_d     = rd_in_range ? mem_rdata : '0;
                tx_valid_d = 1'b1;
                err_d      = ~rd_in_range;
                state_d    = ST_TX;
            end
            ST_TX: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                    if (AUTO_INC) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign bus.rx_ready = (state_q == ST_IDLE);
    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

endmodule
